// File: rtl/fat32_pkg.sv
// FAT32 constants, walker state encoding and FAT addressing helper.
package fat32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EVAL,
    ST_DONE
  } fat_state_t;

  localparam logic [31:0] FAT_EOF_MIN    = 32'h0FFF_FFF8;
  localparam logic [31:0] FAT_BAD        = 32'h0FFF_FFF7;
  localparam logic [31:0] FAT_ENTRY_MASK = 32'h0FFF_FFFF;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_FREE = 2'b01;
  localparam logic [1:0] ERR_BAD  = 2'b10;
  localparam logic [1:0] ERR_LOOP = 2'b11;

  localparam int unsigned ENTRIES_PER_BLOCK_LOG2 = 7;

  // Block holding the FAT entry of a cluster (128 32-bit entries per 512-byte block).
  function automatic logic [31:0] fat_block_of(input logic [31:0] fat1_begin,
                                               input logic [31:0] clust);
    return fat1_begin + (clust >> ENTRIES_PER_BLOCK_LOG2);
  endfunction

endpackage

// File: rtl/fat_result_calc.sv
// File size and last-cluster block address from chain length, cluster and geometry.
module fat_result_calc #(
  parameter int unsigned BLOCK_BYTES_LOG2 = 9
) (
  input  logic [31:0] clust_count,
  input  logic [31:0] clust_num,
  input  logic [31:0] first_file_begining,
  input  logic [31:0] blocks_in_clust,
  output logic [31:0] file_size_bytes,
  output logic [31:0] addr_last_clust
);

  logic [31:0] blocks_total;

  // All arithmetic wraps at 32 bits; cluster numbering starts at 2.
  always_comb begin
    blocks_total    = clust_count * blocks_in_clust;
    file_size_bytes = blocks_total << BLOCK_BYTES_LOG2;
    addr_last_clust = first_file_begining + (clust_num - 32'd2) * blocks_in_clust;
  end

endmodule

// File: rtl/fat_chain_reader.sv
// Walks a FAT32 cluster chain through FAT1 word reads and reports the resume state.
module fat_chain_reader
  import fat32_pkg::*;
#(
  parameter logic [31:0]  MAX_CHAIN        = 32'd65536,
  parameter int unsigned  BLOCK_BYTES_LOG2 = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENA,
  output logic        COMPLT,
  output logic [1:0]  ERR,
  input  logic [31:0] FIRST_FILE_BEGINING,
  input  logic [31:0] FAT1_BEGIN,
  input  logic [31:0] BLOCKS_IN_CLUST,
  input  logic [31:0] FIRST_CLUST,
  output logic        RD_REQ,
  output logic [31:0] RD_BLOCK,
  output logic [6:0]  RD_WORD,
  input  logic        RD_VALID,
  input  logic [31:0] RD_DATA,
  output logic [31:0] CLUST_NUM_EOF,
  output logic [31:0] CLUST_COUNT,
  output logic [31:0] FILE_SIZE_BYTES,
  output logic [31:0] ADDR_LAST_CLUST
);

  fat_state_t  state;
  fat_state_t  state_nxt;

  logic        ena_q;
  logic        ena_rise;
  logic        first_invalid;

  logic [31:0] fat1_q;
  logic [31:0] ffb_q;
  logic [31:0] bic_q;
  logic [31:0] cur;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic [31:0] nxt_q;

  logic        is_eof;
  logic        is_bad;
  logic        is_free;
  logic        is_loop;
  logic        walk_end;

  logic [31:0] size_calc;
  logic [31:0] addr_calc;

  assign ena_rise      = ENA & ~ena_q;
  assign first_invalid = (FIRST_CLUST < 32'd2);
  assign cnt_inc       = cnt + 32'd1;

  // Entry classification for the cluster just read; priority is EOF, bad, free, length limit.
  always_comb begin
    is_eof   = (nxt_q >= FAT_EOF_MIN);
    is_bad   = (nxt_q == FAT_BAD);
    is_free  = (nxt_q < 32'd2);
    is_loop  = (cnt_inc == MAX_CHAIN);
    walk_end = is_eof | is_bad | is_free | is_loop;
  end

  fat_result_calc #(
    .BLOCK_BYTES_LOG2 (BLOCK_BYTES_LOG2)
  ) u_result_calc (
    .clust_count         (cnt),
    .clust_num           (CLUST_NUM_EOF),
    .first_file_begining (ffb_q),
    .blocks_in_clust     (bic_q),
    .file_size_bytes     (size_calc),
    .addr_last_clust     (addr_calc)
  );

  // Walker state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (ena_rise) begin
          state_nxt = first_invalid ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (RD_VALID) begin
          state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: state_nxt = walk_end ? ST_DONE : ST_REQ;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath, read port and result registers; everything clears on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ena_q           <= 1'b0;
      fat1_q          <= '0;
      ffb_q           <= '0;
      bic_q           <= '0;
      cur             <= '0;
      cnt             <= '0;
      nxt_q           <= '0;
      COMPLT          <= 1'b0;
      ERR             <= ERR_OK;
      RD_REQ          <= 1'b0;
      RD_BLOCK        <= '0;
      RD_WORD         <= '0;
      CLUST_NUM_EOF   <= '0;
      CLUST_COUNT     <= '0;
      FILE_SIZE_BYTES <= '0;
      ADDR_LAST_CLUST <= '0;
    end else begin
      ena_q <= ENA;
      unique case (state)
        ST_IDLE: begin
          if (ena_rise) begin
            fat1_q <= FAT1_BEGIN;
            ffb_q  <= FIRST_FILE_BEGINING;
            bic_q  <= BLOCKS_IN_CLUST;
            cur    <= FIRST_CLUST;
            cnt    <= '0;
            COMPLT <= 1'b0;
            ERR    <= first_invalid ? ERR_FREE : ERR_OK;
          end
        end
        ST_REQ: begin
          // Registered request: address and strobe are valid from the first WAIT cycle on.
          RD_REQ   <= 1'b1;
          RD_BLOCK <= fat_block_of(fat1_q, cur);
          RD_WORD  <= cur[ENTRIES_PER_BLOCK_LOG2-1:0];
        end
        ST_WAIT: begin
          if (RD_VALID) begin
            nxt_q  <= RD_DATA & FAT_ENTRY_MASK;
            RD_REQ <= 1'b0;
          end
        end
        ST_EVAL: begin
          cnt <= cnt_inc;
          if (is_eof) begin
            CLUST_NUM_EOF <= cur;
            ERR           <= ERR_OK;
          end else if (is_bad) begin
            CLUST_NUM_EOF <= cur;
            ERR           <= ERR_BAD;
          end else if (is_free) begin
            CLUST_NUM_EOF <= cur;
            ERR           <= ERR_FREE;
          end else if (is_loop) begin
            ERR <= ERR_LOOP;
          end else begin
            cur <= nxt_q;
          end
        end
        ST_DONE: begin
          CLUST_COUNT     <= cnt;
          FILE_SIZE_BYTES <= size_calc;
          ADDR_LAST_CLUST <= addr_calc;
          COMPLT          <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fat_chain_reader.sv
// Randomized self-checking bench for fat_chain_reader against a chain-walking model.
module tb_fat_chain_reader;

  localparam logic [31:0] MAXC = 32'd8;
  localparam logic [31:0] FAT1 = 32'd14462;
  localparam logic [31:0] FFB  = 32'd16448;
  localparam logic [31:0] BIC  = 32'd64;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ENA;
  logic        COMPLT;
  logic [1:0]  ERR;
  logic [31:0] FIRST_FILE_BEGINING;
  logic [31:0] FAT1_BEGIN;
  logic [31:0] BLOCKS_IN_CLUST;
  logic [31:0] FIRST_CLUST;
  logic        RD_REQ;
  logic [31:0] RD_BLOCK;
  logic [6:0]  RD_WORD;
  logic        RD_VALID;
  logic [31:0] RD_DATA;
  logic [31:0] CLUST_NUM_EOF;
  logic [31:0] CLUST_COUNT;
  logic [31:0] FILE_SIZE_BYTES;
  logic [31:0] ADDR_LAST_CLUST;

  int unsigned total = 0;
  int unsigned bad   = 0;

  fat_chain_reader #(
    .MAX_CHAIN        (MAXC),
    .BLOCK_BYTES_LOG2 (9)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .ENA                 (ENA),
    .COMPLT              (COMPLT),
    .ERR                 (ERR),
    .FIRST_FILE_BEGINING (FIRST_FILE_BEGINING),
    .FAT1_BEGIN          (FAT1_BEGIN),
    .BLOCKS_IN_CLUST     (BLOCKS_IN_CLUST),
    .FIRST_CLUST         (FIRST_CLUST),
    .RD_REQ              (RD_REQ),
    .RD_BLOCK            (RD_BLOCK),
    .RD_WORD             (RD_WORD),
    .RD_VALID            (RD_VALID),
    .RD_DATA             (RD_DATA),
    .CLUST_NUM_EOF       (CLUST_NUM_EOF),
    .CLUST_COUNT         (CLUST_COUNT),
    .FILE_SIZE_BYTES     (FILE_SIZE_BYTES),
    .ADDR_LAST_CLUST     (ADDR_LAST_CLUST)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // ---------------- card FAT image and reference model ----------------
  logic [31:0] fat [logic [31:0]];
  logic [31:0] exp_reads [$];
  logic [1:0]  exp_err;
  logic [31:0] exp_eof, exp_cnt, exp_size, exp_addr;
  logic [31:0] model_eof = 32'd0;

  // Follow the chain in the FAT image and predict every result of one walk.
  task automatic model_walk(input logic [31:0] first);
    logic [31:0] c;
    logic [31:0] n;
    logic [31:0] e;
    exp_reads.delete();
    n = 0;
    if (first < 2) begin
      exp_err = 2'b01;
    end else begin
      c = first;
      forever begin
        exp_reads.push_back(c);
        e = (fat.exists(c) ? fat[c] : 32'd0) & 32'h0FFF_FFFF;
        n++;
        if (e >= 32'h0FFF_FFF8)      begin exp_err = 2'b00; model_eof = c; break; end
        else if (e == 32'h0FFF_FFF7) begin exp_err = 2'b10; model_eof = c; break; end
        else if (e < 2)              begin exp_err = 2'b01; model_eof = c; break; end
        else if (n == MAXC)          begin exp_err = 2'b11; break; end
        c = e;
      end
    end
    exp_cnt  = n;
    exp_eof  = model_eof;
    exp_size = exp_cnt * BIC * 32'd512;
    exp_addr = FFB + (model_eof - 32'd2) * BIC;
  endtask

  // ---------------- memory responder ----------------
  int unsigned max_lat = 0;
  int unsigned min_lat = 0;
  bit          spurious = 1'b0;
  logic [31:0] rd_blk_q [$];
  logic [6:0]  rd_wrd_q [$];

  initial begin : responder
    bit          pend;
    bit          chk_drop;
    int unsigned lat_left;
    logic [31:0] pend_blk;
    logic [6:0]  pend_wrd;
    logic [31:0] cl;
    pend = 0; chk_drop = 0; lat_left = 0; pend_blk = 0; pend_wrd = 0;
    RD_VALID = 1'b0;
    RD_DATA  = 32'd0;
    forever begin
      @(negedge CLK);
      RD_VALID = 1'b0;
      if (RST) begin
        pend = 0;
        chk_drop = 0;
      end else begin
        if (chk_drop) begin
          chk_drop = 0;
          check("rd_req_drop", 32'(RD_REQ), 32'd0);
        end
        if (spurious) begin
          spurious = 0;
          RD_VALID = 1'b1;
          RD_DATA  = 32'h0000_0005;
        end else if (RD_REQ) begin
          if (!pend) begin
            pend     = 1;
            pend_blk = RD_BLOCK;
            pend_wrd = RD_WORD;
            rd_blk_q.push_back(RD_BLOCK);
            rd_wrd_q.push_back(RD_WORD);
            lat_left = $urandom_range(max_lat, min_lat);
          end else begin
            check("rd_block_stable", RD_BLOCK, pend_blk);
            check("rd_word_stable", 32'(RD_WORD), 32'(pend_wrd));
          end
          if (lat_left == 0) begin
            cl       = ((pend_blk - FAT1) << 7) | 32'(pend_wrd);
            RD_VALID = 1'b1;
            RD_DATA  = fat.exists(cl) ? fat[cl] : 32'd0;
            pend     = 0;
            chk_drop = 1;
          end else begin
            lat_left--;
          end
        end
      end
    end
  end

  // ---------------- result checker ----------------
  bit armed = 1'b0;

  always @(negedge CLK) begin
    if (armed && !RST && COMPLT) begin
      check("err",             32'(ERR),        32'(exp_err));
      check("clust_num_eof",   CLUST_NUM_EOF,   exp_eof);
      check("clust_count",     CLUST_COUNT,     exp_cnt);
      check("file_size_bytes", FILE_SIZE_BYTES, exp_size);
      check("addr_last_clust", ADDR_LAST_CLUST, exp_addr);
      check("rd_req_idle",     32'(RD_REQ),     32'd0);
    end
  end

  // One complete walk: fresh ENA edge, bounded wait, read-sequence check.
  task automatic run_walk(input logic [31:0] first, input int unsigned lat, input string tag);
    logic        prev_complt;
    int unsigned cycles;
    armed   = 0;
    max_lat = lat;
    min_lat = 0;
    rd_blk_q.delete();
    rd_wrd_q.delete();
    model_walk(first);
    @(posedge CLK); #1;
    ENA                 = 1'b0;
    FIRST_CLUST         = first;
    FAT1_BEGIN          = FAT1;
    FIRST_FILE_BEGINING = FFB;
    BLOCKS_IN_CLUST     = BIC;
    @(posedge CLK); #1;
    ENA = 1'b1;
    prev_complt = COMPLT;
    @(posedge CLK); #1;
    cycles = 1;
    if (prev_complt) check({tag, "_complt_clear"}, 32'(COMPLT), 32'd0);
    while (!COMPLT && cycles < 2000) begin
      @(posedge CLK); #1;
      cycles++;
    end
    check({tag, "_complt"}, 32'(COMPLT), 32'd1);
    if (lat == 0) check({tag, "_latency"}, cycles, 32'(3 * exp_reads.size() + 2));
    check({tag, "_n_reads"}, 32'(rd_blk_q.size()), 32'(exp_reads.size()));
    for (int i = 0; i < rd_blk_q.size() && i < exp_reads.size(); i++) begin
      check({tag, "_rd_block"}, rd_blk_q[i], FAT1 + (exp_reads[i] >> 7));
      check({tag, "_rd_word"}, 32'(rd_wrd_q[i]), exp_reads[i] & 32'h7F);
    end
    armed = 1;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] first;
    logic [31:0] cur;
    logic [31:0] c;
    int unsigned len;
    int unsigned n0;
    RST = 1'b1; ENA = 1'b0;
    FIRST_CLUST = 32'd2; FAT1_BEGIN = FAT1; FIRST_FILE_BEGINING = FFB; BLOCKS_IN_CLUST = BIC;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_complt", 32'(COMPLT), 32'd0);
    check("rst_err",    32'(ERR),    32'd0);
    check("rst_rd_req", 32'(RD_REQ), 32'd0);
    check("rst_eof",    CLUST_NUM_EOF,   32'd0);
    check("rst_count",  CLUST_COUNT,     32'd0);
    check("rst_size",   FILE_SIZE_BYTES, 32'd0);
    check("rst_addr",   ADDR_LAST_CLUST, 32'd0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Chain 2 -> 3 -> 4 -> EOF.
    fat.delete();
    fat[2] = 32'd3; fat[3] = 32'd4; fat[4] = 32'h0FFF_FFFF;
    run_walk(32'd2, 0, "chainA");
    check("A_eof",   CLUST_NUM_EOF,   32'd4);
    check("A_count", CLUST_COUNT,     32'd3);
    check("A_size",  FILE_SIZE_BYTES, 32'd98304);
    check("A_addr",  ADDR_LAST_CLUST, 32'd16576);
    check("A_err",   32'(ERR),        32'd0);
    check("A_blk0",  rd_blk_q[0],     32'd14462);
    check("A_wrd2",  32'(rd_wrd_q[2]), 32'd4);

    // ENA held high after completion: no second walk.
    n0 = rd_blk_q.size();
    repeat (10) @(posedge CLK);
    #1;
    check("hold_no_reads", 32'(rd_blk_q.size()), 32'(n0));
    check("hold_complt",   32'(COMPLT), 32'd1);

    // Spurious RD_VALID while idle.
    spurious = 1;
    repeat (5) @(posedge CLK);
    #1;
    check("spur_no_reads", 32'(rd_blk_q.size()), 32'(n0));
    check("spur_eof",      CLUST_NUM_EOF, 32'd4);

    // Chain 2 -> 130 -> EOF with upper nibble set.
    fat.delete();
    fat[2] = 32'd130; fat[130] = 32'hFFFF_FFF8;
    run_walk(32'd2, 0, "chainB");
    check("B_blk1",  rd_blk_q[1], 32'd14463);
    check("B_wrd1",  32'(rd_wrd_q[1]), 32'd2);
    check("B_eof",   CLUST_NUM_EOF, 32'd130);
    check("B_count", CLUST_COUNT,   32'd2);

    // Bad-cluster mark.
    fat.delete();
    fat[2] = 32'h0FFF_FFF7;
    run_walk(32'd2, 0, "bad");
    check("bad_err", 32'(ERR),      32'd2);
    check("bad_eof", CLUST_NUM_EOF, 32'd2);

    // Free entry in chain.
    fat.delete();
    fat[2] = 32'd0;
    run_walk(32'd2, 0, "free");
    check("free_err",   32'(ERR),    32'd1);
    check("free_count", CLUST_COUNT, 32'd1);

    // Loop 2 -> 3 -> 2 hits the chain limit.
    fat.delete();
    fat[2] = 32'd3; fat[3] = 32'd2;
    run_walk(32'd2, 0, "loop");
    check("loop_err",   32'(ERR),    32'd3);
    check("loop_count", CLUST_COUNT, 32'd8);
    check("loop_reads", 32'(rd_blk_q.size()), 32'd8);

    // Invalid first cluster: no read.
    run_walk(32'd1, 0, "first1");
    check("first1_err",   32'(ERR),    32'd1);
    check("first1_count", CLUST_COUNT, 32'd0);
    check("first1_reads", 32'(rd_blk_q.size()), 32'd0);

    // Random chains, random latency then zero latency.
    for (int t = 0; t < 12; t++) begin
      fat.delete();
      first = $urandom_range(3000, 2);
      cur = first;
      fat[cur] = 32'd0;
      len = $urandom_range(6, 1);
      for (int i = 1; i < int'(len); i++) begin
        do c = $urandom_range(3000, 2); while (fat.exists(c));
        fat[cur] = c | ($urandom & 32'hF000_0000);
        fat[c] = 32'd0;
        cur = c;
      end
      case ($urandom_range(3, 0))
        0: fat[cur] = (32'h0FFF_FFF8 + $urandom_range(7, 0)) | ($urandom & 32'hF000_0000);
        1: fat[cur] = 32'h0FFF_FFF7 | ($urandom & 32'hF000_0000);
        2: fat[cur] = $urandom_range(1, 0) | ($urandom & 32'hF000_0000);
        default: fat[cur] = first | ($urandom & 32'hF000_0000);
      endcase
      run_walk(first, 20, "rand");
      run_walk(first, 0, "rand0");
    end

    // Reset in the middle of a read.
    fat.delete();
    fat[2] = 32'd3; fat[3] = 32'd4; fat[4] = 32'h0FFF_FFFF;
    armed = 0;
    @(posedge CLK); #1;
    ENA = 1'b0; FIRST_CLUST = 32'd2;
    min_lat = 15; max_lat = 15;
    @(posedge CLK); #1;
    ENA = 1'b1;
    for (int i = 0; i < 10 && !RD_REQ; i++) begin
      @(posedge CLK); #1;
    end
    check("rstw_req_seen", 32'(RD_REQ), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    ENA = 1'b0;
    RST = 1'b1;
    #1;
    check("rstw_rd_req", 32'(RD_REQ), 32'd0);
    check("rstw_complt", 32'(COMPLT), 32'd0);
    check("rstw_err",    32'(ERR),    32'd0);
    check("rstw_eof",    CLUST_NUM_EOF,   32'd0);
    check("rstw_count",  CLUST_COUNT,     32'd0);
    check("rstw_size",   FILE_SIZE_BYTES, 32'd0);
    check("rstw_addr",   ADDR_LAST_CLUST, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    model_eof = 32'd0;
    min_lat = 0; max_lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      check("rstw_idle_req",    32'(RD_REQ), 32'd0);
      check("rstw_idle_complt", 32'(COMPLT), 32'd0);
    end
    run_walk(32'd2, 0, "after_rst");
    check("after_rst_eof", CLUST_NUM_EOF, 32'd4);

    armed = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
